// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// State encoding plus default widths and the HALT word.
package fetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Output register holding the fetched instruction for decode.
// Flush beats load, load beats accept.
module fetch_out_reg #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic          accept,
  input  logic [DW-1:0] d_instr,
  input  logic [AW-1:0] d_pc,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          valid
);

  // Capture, drop or hand off the held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= d_instr;
      pc    <= d_pc;
      valid <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory,
// presents instructions to decode over valid/ready.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_INSTR =
    DATA_W'(HALT_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  state_e state;
  state_e state_nxt;

  logic [ADDR_W-1:0] pc;
  logic load;
  logic flush;
  logic accept;
  logic pc_redir;
  logic is_halt;

  assign imem_addr = pc;
  assign accept    = instr_valid && instr_ready;
  assign is_halt   = (imem_data == HALT_INSTR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load && is_halt) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control and status outputs
  always_comb begin
    busy     = 1'b0;
    halted   = 1'b0;
    load     = 1'b0;
    flush    = 1'b0;
    pc_redir = 1'b0;
    unique case (state)
      IDLE: begin
        pc_redir = redirect;
      end
      RUN: begin
        busy     = 1'b1;
        flush    = redirect;
        pc_redir = redirect;
        load     = !redirect &&
                   (!instr_valid || instr_ready);
      end
      HALT: begin
        halted = !instr_valid;
      end
      default: ;
    endcase
  end

  // Program counter: redirect target or sequential step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (pc_redir) pc <= redirect_pc;
    else if (load)     pc <= pc + ADDR_W'(1);
  end

  // Count every transfer accepted by decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fetch_count <= '0;
    else if (accept) fetch_count <= fetch_count + 32'd1;
  end

  fetch_out_reg #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .accept  (accept),
    .d_instr (imem_data),
    .d_pc    (pc),
    .instr   (instr_out),
    .pc      (instr_pc),
    .valid   (instr_valid)
  );

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the combinational, word-addressed instruction memory.
- Owns the program counter and drives the memory address.
- Captures each returned instruction into an output register and hands it to decode over a valid/ready handshake.
- Handles control-flow redirects and stops on a HALT encoding.
- Sits between instruction_memory and the decode stage of the lab processor.

Parameters:
ADDR_W, 32, width of PC and memory address (word address, +1 per instruction)
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetching

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, leaves IDLE
imem_addr  out  ADDR_W  address to instruction memory (combinational = pc)
imem_data  in  DATA_W  instruction from memory, same cycle as imem_addr
instr_out  out  DATA_W  registered instruction to decode
instr_pc  out  ADDR_W  address instr_out was fetched from
instr_valid  out  1  instr_out/instr_pc valid
instr_ready  in  1  decode accepts when valid&&ready
redirect  in  1  branch/jump taken, flush and refetch
redirect_pc  in  ADDR_W  new PC when redirect=1
busy  out  1  state==RUN
halted  out  1  state==HALT && !instr_valid
fetch_count  out  32  number of accepted instructions (valid&&ready)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, fetch_count=0. Outputs derived from these: busy=0, halted=0, imem_addr=RESET_PC.
- States: IDLE, RUN, HALT (2-bit enum).
- IDLE:
  - start=1 -> RUN next edge.
  - redirect=1 loads pc<=redirect_pc and stays IDLE.
  - No capture while in IDLE.
- RUN: load = !instr_valid || instr_ready. Priority, highest first:
  1. redirect=1: instr_valid<=0, pc<=redirect_pc, no capture this cycle.
  2. load=1: instr_out<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1. If imem_data==HALT_INSTR -> HALT.
  3. Otherwise hold all registers (stall).
- HALT:
  - No further capture; pc frozen; redirect and start ignored.
  - On valid&&ready: instr_valid<=0.
  - Exit only via reset.
- Handshake: instr_out/instr_pc stable while instr_valid && !instr_ready. An accepted transfer in the same cycle as a redirect still counts.
- fetch_count: +1 on every cycle with instr_valid&&instr_ready, in any state; wraps at 2^32.
- Latency: start at edge N -> RUN at N+1 -> instr_valid=1 with instr at RESET_PC after edge N+2. Throughput is 1 instruction/cycle with instr_ready held high.
- Redirect bubble: after a redirect edge, valid=0 for one cycle, then the target instruction is presented.
- PC arithmetic: pc+1 modulo 2^ADDR_W; all-ones wraps to 0 silently.
- start while in RUN or HALT: ignored.
- Reset mid-RUN: all registers return to reset values immediately; the held instruction is discarded.

Decomposition:
- Shared package fetch_pkg: state enum (IDLE/RUN/HALT), HALT_INSTR default constant, ADDR_W/DATA_W defaults.
- One sub-module fetch_out_reg: output register for instr_out/instr_pc/instr_valid with load/flush/accept inputs. The FSM, PC and counter stay in imem_fetch_ctrl.

Test Plan:
- Reset + start: memory model with mem[0..3]=32'h11,22,33,44, ready=1, start at cycle 0 -> valid at cycle 2 with instr_out 0x11/pc 0, then 0x22/1, 0x33/2, 0x44/3 on consecutive cycles; fetch_count=4 after 4 accepts.
- Back-pressure: ready=0 for 3 cycles while instr_out=0x22 -> instr_out, instr_pc=1 and imem_addr=2 held; ready=1 -> 0x33 next cycle, no loss or duplicate.
- Redirect: while 0x22 is valid, redirect=1, redirect_pc=3 -> valid=0 next cycle, then 0x44/pc 3; the in-flight 0x22 is counted only if ready was 1 that cycle.
- Halt: mem[2]=32'hFFFF_FFFF -> HALT word presented with pc 2; after it is accepted, halted=1, busy=0, imem_addr stays 3; later start/redirect pulses have no effect.
- Wrap: redirect_pc=32'hFFFF_FFFF in IDLE, then start -> pc sequence FFFF_FFFF, 0, 1.
- Async reset mid-RUN, asserted between clock edges -> instr_valid=0 and imem_addr=RESET_PC immediately; state IDLE; fetch_count=0.
